fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Pipeline control unit that sequences the fetch stage.
- Generates the fetch stop/hold, pipeline flush and PC-redirect controls from hazard, branch, memory-busy and halt/resume events.
- Sits between decode/execute hazard logic and the fetch stage's PC register.
- Also provides a post-reset boot hold, so fetch starts cleanly after memories settle.

Parameters:
- PC_W, 12, width of program counter and branch target.
- BOOT_CYCLES, 4, cycles fetch is held stopped after reset (≥1).
- FLUSH_CYCLES, 2, cycles o_flush stays asserted after a taken branch (≥1).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_branch_taken  in  1  execute stage resolved a taken branch/jump this cycle.
- i_branch_target  in  PC_W  redirect address, valid with i_branch_taken.
- i_load_use  in  1  decode-detected load-use hazard; level, held while hazard exists.
- i_mem_busy  in  1  instruction memory not ready; level.
- i_halt  in  1  HALT instruction retired; single-cycle pulse.
- i_resume  in  1  external resume request; single-cycle pulse.
- o_stop  out  1  hold PC and fetch output register.
- o_flush  out  1  squash IF/ID and ID/EX contents (insert bubbles).
- o_pc_load  out  1  one-cycle strobe: load o_pc_target into PC.
- o_pc_target  out  PC_W  redirect address.
- o_halted  out  1  sequencer in HALT state.
- o_state  out  3  current state encoding, for debug.
- o_stall_cnt  out  16  stall-cycle count (optional feature).
- o_flush_cnt  out  16  branch-flush event count (optional feature).

Behaviour:
- All outputs are registered.
  - An input sampled at edge N affects outputs after edge N.
  - Hazard logic must therefore raise i_load_use one cycle ahead.
- Reset (i_reset=1 at an edge, any state, including mid-flush):
  - state=BOOT, cnt=BOOT_CYCLES-1.
  - o_stop=1, o_flush=1, o_pc_load=0, o_pc_target=0.
  - o_halted=0, o_stall_cnt=0, o_flush_cnt=0.
- State encodings: BOOT=0, RUN=1, STALL=2, FLUSH=3, HALT=4.
- BOOT:
  - stop=1, flush=1; all event inputs ignored.
  - cnt decrements each cycle; at cnt==0 go to RUN.
  - Stop is therefore asserted for exactly BOOT_CYCLES cycles after reset deassertion.
- RUN:
  - stop=0, flush=0.
  - Priority per cycle: branch > halt > (load_use | mem_busy).
  - Branch:
    - Register o_pc_target=i_branch_target and o_pc_load=1 for one cycle.
    - flush=1, cnt=FLUSH_CYCLES-1, go to FLUSH.
  - Halt: go to HALT.
  - Hazard: go to STALL.
- STALL:
  - stop=1, flush=0.
  - Remain while i_load_use|i_mem_busy.
  - Branch during STALL takes priority: do the redirect exactly as in RUN and go to FLUSH.
  - Halt during STALL: go to HALT.
  - Otherwise return to RUN.
- FLUSH:
  - flush=1, stop=0, pc_load=0 after the first cycle.
  - Decrement cnt; at cnt==0 go to RUN (or STALL if a hazard is asserted).
  - New branch during FLUSH: re-load target, pulse pc_load again, restart cnt; the newest target wins.
  - Halt is ignored in FLUSH (the squashed instruction cannot halt).
- HALT:
  - stop=1, flush=0, o_halted=1.
  - Branch, hazard and halt are ignored.
  - i_resume goes to RUN; o_halted drops the same edge.
  - i_resume in any state other than HALT is ignored.
- Simultaneous i_halt and i_resume in RUN: halt wins; resume is ignored.
- o_pc_target holds its last value when o_pc_load=0.

Optional Feature:
- FETCH_SEQ_PERF_EN defined:
  - o_stall_cnt increments every cycle spent in STALL.
  - o_flush_cnt increments on every o_pc_load strobe.
  - Both counters are 16-bit, saturate at 0xFFFF and clear on reset.
- Not defined: both ports are driven constant 0 and no counter flops are synthesized.

Decomposition:
- Shared package cpu_ctrl_pkg:
  - State enum: BOOT, RUN, STALL, FLUSH, HALT with encodings above.
  - PC_W default constant.
  - Perf counter width constant (16).
- One sub-module, sat_counter: width-parameterised saturating incrementer with sync clear, instantiated twice under the macro.

Test Plan:
- Reset release with BOOT_CYCLES=4 -> o_stop=1 and o_flush=1 for exactly 4 cycles, then o_stop=0 and o_state=1.
- RUN, i_branch_taken=1 with target 0x3A0 -> next cycle o_pc_load=1 and o_pc_target=0x3A0; o_flush=1 for 2 cycles; o_flush_cnt=1.
- i_load_use held 3 cycles -> o_stop=1 for 3 cycles, o_stall_cnt=3, then RUN.
- In STALL, branch to 0x010 with i_mem_busy=1 -> o_pc_load pulse with 0x010, then FLUSH, then STALL after flush ends while busy is still high.
- i_halt pulse -> o_halted=1 and o_stop=1; a branch while halted is ignored; i_resume -> o_halted=0 and o_stop=0 next cycle.
- i_reset asserted mid-FLUSH -> next cycle state=BOOT, o_pc_load=0, o_pc_target=0x000, counters 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the fetch-control slice: sequencer state encoding and
// default widths for the program counter and the performance counters.
package cpu_ctrl_pkg;

   localparam int PC_W_DEF = 12;
   localparam int PERF_W   = 16;

   typedef enum logic [2:0] {
      BOOT  = 3'd0,
      RUN   = 3'd1,
      STALL = 3'd2,
      FLUSH = 3'd3,
      HALT  = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised incrementer that sticks at all-ones; synchronous clear
// has priority over increment.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_clr,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (i_clr) begin
         count_d = '0;
      end else if (i_inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      count_q <= count_d;
   end

   assign o_count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: boot hold, hazard stall, branch flush/redirect, halt.
// Stall/flush event counters exist only when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int PC_W         = PC_W_DEF,
   parameter int BOOT_CYCLES  = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_branch_taken,
   input  logic [PC_W-1:0]   i_branch_target,
   input  logic              i_load_use,
   input  logic              i_mem_busy,
   input  logic              i_halt,
   input  logic              i_resume,
   output logic              o_stop,
   output logic              o_flush,
   output logic              o_pc_load,
   output logic [PC_W-1:0]   o_pc_target,
   output logic              o_halted,
   output logic [2:0]        o_state,
   output logic [PERF_W-1:0] o_stall_cnt,
   output logic [PERF_W-1:0] o_flush_cnt
);

   localparam int CNT_MAX = (BOOT_CYCLES > FLUSH_CYCLES) ? BOOT_CYCLES : FLUSH_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   fetch_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              stop_q, stop_d;
   logic              flush_q, flush_d;
   logic              pc_load_q, pc_load_d;
   logic [PC_W-1:0]   pc_target_q, pc_target_d;
   logic              halted_q, halted_d;
   logic              hazard;
   logic              redirect;

   assign hazard = i_load_use | i_mem_busy;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_target_d = pc_target_q;
      pc_load_d   = 1'b0;
      redirect    = 1'b0;

      case (state_q)
         BOOT: begin
            if (cnt_q == '0) state_d = RUN;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         RUN: begin
            if (i_branch_taken) redirect = 1'b1;
            else if (i_halt)    state_d  = HALT;
            else if (hazard)    state_d  = STALL;
         end
         STALL: begin
            if (i_branch_taken) redirect = 1'b1;
            else if (i_halt)    state_d  = HALT;
            else if (!hazard)   state_d  = RUN;
         end
         FLUSH: begin
            // Halt is deliberately ignored: the retiring instruction is being squashed.
            if (i_branch_taken)   redirect = 1'b1;
            else if (cnt_q == '0) state_d  = hazard ? STALL : RUN;
            else                  cnt_d    = cnt_q - CNT_W'(1);
         end
         HALT: begin
            if (i_resume) state_d = RUN;
         end
         default: begin
            state_d = BOOT;
            cnt_d   = CNT_W'(BOOT_CYCLES - 1);
         end
      endcase

      if (redirect) begin
         state_d     = FLUSH;
         cnt_d       = CNT_W'(FLUSH_CYCLES - 1);
         pc_load_d   = 1'b1;
         pc_target_d = i_branch_target;
      end

      // Outputs are decoded from the next state so they line up with it after the edge.
      stop_d   = (state_d == BOOT) || (state_d == STALL) || (state_d == HALT);
      flush_d  = (state_d == BOOT) || (state_d == FLUSH);
      halted_d = (state_d == HALT);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= BOOT;
         cnt_q       <= CNT_W'(BOOT_CYCLES - 1);
         stop_q      <= 1'b1;
         flush_q     <= 1'b1;
         pc_load_q   <= 1'b0;
         pc_target_q <= '0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stop_q      <= stop_d;
         flush_q     <= flush_d;
         pc_load_q   <= pc_load_d;
         pc_target_q <= pc_target_d;
         halted_q    <= halted_d;
      end
   end

   assign o_stop      = stop_q;
   assign o_flush     = flush_q;
   assign o_pc_load   = pc_load_q;
   assign o_pc_target = pc_target_q;
   assign o_halted    = halted_q;
   assign o_state     = state_q;

`ifdef FETCH_SEQ_PERF_EN
   sat_counter #(.W(PERF_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_clr   (i_reset),
      .i_inc   (state_d == STALL),
      .o_count (o_stall_cnt)
   );

   sat_counter #(.W(PERF_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_clr   (i_reset),
      .i_inc   (pc_load_d),
      .o_count (o_flush_cnt)
   );
`else
   assign o_stall_cnt = '0;
   assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scenario bench for fetch_sequencer: per-cycle expected outputs are queued as
// stimulus is applied and compared one cycle later.
module tb_fetch_sequencer;

`ifdef FETCH_SEQ_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, br, lu, mb, hlt, res;
   logic [11:0] tgt;
   logic        o_stop, o_flush, o_pc_load, o_halted;
   logic [11:0] o_pc_target;
   logic [2:0]  o_state;
   logic [15:0] o_stall_cnt, o_flush_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic rst; logic br; logic [11:0] tgt; logic lu; logic mb; logic hlt; logic res;
   } stim_t;

   typedef struct packed {
      logic stop; logic flush; logic pcl; logic [11:0] tgt;
      logic halted; logic [2:0] state; logic [15:0] scnt; logic [15:0] fcnt;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .i_clk(clk), .i_reset(rst), .i_branch_taken(br), .i_branch_target(tgt),
      .i_load_use(lu), .i_mem_busy(mb), .i_halt(hlt), .i_resume(res),
      .o_stop(o_stop), .o_flush(o_flush), .o_pc_load(o_pc_load),
      .o_pc_target(o_pc_target), .o_halted(o_halted), .o_state(o_state),
      .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
   );

   function automatic stim_t st(logic r, logic b, logic [11:0] t, logic l, logic m, logic h, logic s);
      return '{rst:r, br:b, tgt:t, lu:l, mb:m, hlt:h, res:s};
   endfunction

   function automatic exp_t ex(logic sp, logic fl, logic pl, logic [11:0] t, logic ha,
                               logic [2:0] s, int sc, int fc);
      return '{stop:sp, flush:fl, pcl:pl, tgt:t, halted:ha, state:s,
               scnt:(PERF ? 16'(sc) : 16'h0), fcnt:(PERF ? 16'(fc) : 16'h0)};
   endfunction

   function automatic exp_t observe();
      return '{stop:o_stop, flush:o_flush, pcl:o_pc_load, tgt:o_pc_target, halted:o_halted,
               state:o_state, scnt:o_stall_cnt, fcnt:o_flush_cnt};
   endfunction

   task automatic drive(stim_t s);
      rst = s.rst; br = s.br; tgt = s.tgt; lu = s.lu; mb = s.mb; hlt = s.hlt; res = s.res;
   endtask

   task automatic test_reset();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,12'h0,0,0,0,0)); e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,1,12'h555,1,1,1,1)); e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,0,12'h0,0,0,0,0)); e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,0,12'h0,0,0,0,0)); e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,0,12'h0,0,0,0,0)); e.push_back(ex(0,0,0,12'h000,0,3'd1,0,0));
      foreach (s[i]) begin
         drive(s[i]); sb.push_back(e[i]);
         @(posedge clk); #1;
         want = sb.pop_front(); got = observe(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset row=%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_branch();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0,1,12'h3A0,0,0,0,0)); e.push_back(ex(0,1,1,12'h3A0,0,3'd3,0,1));
      s.push_back(st(0,0,12'h0,0,0,0,0));   e.push_back(ex(0,1,0,12'h3A0,0,3'd3,0,1));
      s.push_back(st(0,0,12'h0,0,0,0,0));   e.push_back(ex(0,0,0,12'h3A0,0,3'd1,0,1));
      foreach (s[i]) begin
         drive(s[i]); sb.push_back(e[i]);
         @(posedge clk); #1;
         want = sb.pop_front(); got = observe(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL branch row=%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_stall();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0,0,12'h0,1,0,0,0)); e.push_back(ex(1,0,0,12'h3A0,0,3'd2,1,1));
      s.push_back(st(0,0,12'h0,1,0,0,0)); e.push_back(ex(1,0,0,12'h3A0,0,3'd2,2,1));
      s.push_back(st(0,0,12'h0,1,0,0,1)); e.push_back(ex(1,0,0,12'h3A0,0,3'd2,3,1));
      s.push_back(st(0,0,12'h0,0,0,0,1)); e.push_back(ex(0,0,0,12'h3A0,0,3'd1,3,1));
      foreach (s[i]) begin
         drive(s[i]); sb.push_back(e[i]);
         @(posedge clk); #1;
         want = sb.pop_front(); got = observe(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL stall row=%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_stall_branch();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0,0,12'h0,0,1,0,0));   e.push_back(ex(1,0,0,12'h3A0,0,3'd2,4,1));
      s.push_back(st(0,1,12'h010,0,1,1,0)); e.push_back(ex(0,1,1,12'h010,0,3'd3,4,2));
      s.push_back(st(0,0,12'h0,0,1,0,0));   e.push_back(ex(0,1,0,12'h010,0,3'd3,4,2));
      s.push_back(st(0,0,12'h0,0,1,0,0));   e.push_back(ex(1,0,0,12'h010,0,3'd2,5,2));
      s.push_back(st(0,0,12'h0,0,0,0,0));   e.push_back(ex(0,0,0,12'h010,0,3'd1,5,2));
      foreach (s[i]) begin
         drive(s[i]); sb.push_back(e[i]);
         @(posedge clk); #1;
         want = sb.pop_front(); got = observe(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL stall_branch row=%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_halt();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0,0,12'h0,0,0,1,0));   e.push_back(ex(1,0,0,12'h010,1,3'd4,5,2));
      s.push_back(st(0,1,12'h7FF,1,1,1,0)); e.push_back(ex(1,0,0,12'h010,1,3'd4,5,2));
      s.push_back(st(0,0,12'h0,0,0,0,1));   e.push_back(ex(0,0,0,12'h010,0,3'd1,5,2));
      s.push_back(st(0,0,12'h0,0,0,1,1));   e.push_back(ex(1,0,0,12'h010,1,3'd4,5,2));
      s.push_back(st(0,0,12'h0,0,0,0,0));   e.push_back(ex(1,0,0,12'h010,1,3'd4,5,2));
      s.push_back(st(0,0,12'h0,0,0,0,1));   e.push_back(ex(0,0,0,12'h010,0,3'd1,5,2));
      foreach (s[i]) begin
         drive(s[i]); sb.push_back(e[i]);
         @(posedge clk); #1;
         want = sb.pop_front(); got = observe(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL halt row=%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(0,1,12'h111,0,0,0,0)); e.push_back(ex(0,1,1,12'h111,0,3'd3,5,3));
      s.push_back(st(0,1,12'h222,0,0,0,0)); e.push_back(ex(0,1,1,12'h222,0,3'd3,5,4));
      s.push_back(st(0,0,12'h0,0,0,1,0));   e.push_back(ex(0,1,0,12'h222,0,3'd3,5,4));
      s.push_back(st(0,0,12'h0,0,0,0,0));   e.push_back(ex(0,0,0,12'h222,0,3'd1,5,4));
      s.push_back(st(0,1,12'h0AB,0,0,1,0)); e.push_back(ex(0,1,1,12'h0AB,0,3'd3,5,5));
      foreach (s[i]) begin
         drive(s[i]); sb.push_back(e[i]);
         @(posedge clk); #1;
         want = sb.pop_front(); got = observe(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL back_to_back row=%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   task automatic test_reset_mid_flush();
      stim_t s[$]; exp_t e[$]; exp_t got, want;
      s.push_back(st(1,0,12'h0,0,0,0,0));   e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,1,12'h123,0,0,0,0)); e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,0,12'h0,1,0,0,0));   e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,0,12'h0,0,0,1,0));   e.push_back(ex(1,1,0,12'h000,0,3'd0,0,0));
      s.push_back(st(0,0,12'h0,0,0,0,0));   e.push_back(ex(0,0,0,12'h000,0,3'd1,0,0));
      foreach (s[i]) begin
         drive(s[i]); sb.push_back(e[i]);
         @(posedge clk); #1;
         want = sb.pop_front(); got = observe(); total++;
         if (got !== want) begin
            bad++;
            $display("FAIL reset_mid_flush row=%0d got=%h exp=%h", i, got, want);
         end
      end
   endtask

   initial begin
      drive(st(1,0,12'h0,0,0,0,0));
      @(posedge clk); #1;
      test_reset();
      test_branch();
      test_stall();
      test_stall_branch();
      test_halt();
      test_back_to_back();
      test_reset_mid_flush();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
